// File: rtl/hazard_scheduler.sv
// Pipeline hazard controller: tracks EX/MEM/WB destinations and drives stall/bubble and operand forwarding selects.
// Build option: define HAZARD_FWD_EN to enable forwarding (only load-use stalls); undefined, every RAW on EX/MEM stalls.
module hazard_scheduler (
   input  logic        clk,
   input  logic        rst,
   input  logic        id_valid,
   input  logic [2:0]  id_opcode,
   input  logic [2:0]  id_src1,
   input  logic [2:0]  id_src2,
   input  logic [2:0]  id_dst,
   output logic        stall,
   output logic        bubble,
   output logic [1:0]  fwd_a,
   output logic [1:0]  fwd_b,
   output logic [15:0] stall_cycles
);

   typedef enum logic [2:0] {
      OP_NOP = 3'd0,
      OP_LDD = 3'd1,
      OP_STD = 3'd2,
      OP_ADD = 3'd3,
      OP_NOT = 3'd4
   } opcode_e;

`ifdef HAZARD_FWD_EN
   typedef enum logic [1:0] {
      FWD_RF     = 2'b00,
      FWD_EX_MEM = 2'b01,
      FWD_MEM_WB = 2'b10
   } fwd_sel_e;
`endif

   typedef struct packed {
      logic       valid;
      logic       wr;
      logic       ld;
      logic [2:0] dst;
   } shadow_t;

   // Index 0 = EX (youngest), 1 = MEM, 2 = WB.
   shadow_t    pipe_q [3];

   logic       use1;
   logic       use2;
   logic       writes;
   logic       loads;
   logic [2:0] src [2];
   logic       src_used [2];
   logic       found;
   logic       stall_c;
`ifdef HAZARD_FWD_EN
   fwd_sel_e   fwd_sel [2];
`endif

   always_comb begin
      use1   = 1'b0;
      use2   = 1'b0;
      writes = 1'b0;
      loads  = 1'b0;
      if (id_valid) begin
         case (id_opcode)
            OP_LDD: begin
               use1   = 1'b1;
               writes = 1'b1;
               loads  = 1'b1;
            end
            OP_STD: begin
               use1 = 1'b1;
               use2 = 1'b1;
            end
            OP_ADD: begin
               use1   = 1'b1;
               use2   = 1'b1;
               writes = 1'b1;
            end
            OP_NOT: begin
               use1   = 1'b1;
               writes = 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Per source, only the youngest matching entry decides; a WB hit resolves to the regfile.
   always_comb begin
      src[0]      = id_src1;
      src[1]      = id_src2;
      src_used[0] = use1;
      src_used[1] = use2;
      stall_c     = 1'b0;
      found       = 1'b0;
`ifdef HAZARD_FWD_EN
      fwd_sel[0]  = FWD_RF;
      fwd_sel[1]  = FWD_RF;
`endif
      for (int unsigned k = 0; k < 2; k++) begin
         found = 1'b0;
         for (int unsigned i = 0; i < 3; i++) begin
            if (!found && src_used[k] && pipe_q[i].valid && pipe_q[i].wr &&
                pipe_q[i].dst == src[k]) begin
               found = 1'b1;
`ifdef HAZARD_FWD_EN
               if (i == 0) begin
                  if (pipe_q[i].ld)
                     stall_c = 1'b1;
                  else
                     fwd_sel[k] = FWD_EX_MEM;
               end else if (i == 1) begin
                  fwd_sel[k] = FWD_MEM_WB;
               end
`else
               if (i < 2)
                  stall_c = 1'b1;
`endif
            end
         end
      end
   end

   assign stall  = stall_c;
   assign bubble = stall_c;
`ifdef HAZARD_FWD_EN
   assign fwd_a  = fwd_sel[0];
   assign fwd_b  = fwd_sel[1];
`else
   assign fwd_a  = '0;
   assign fwd_b  = '0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < 3; i++)
            pipe_q[i] <= '0;
         stall_cycles <= '0;
      end else begin
         pipe_q[2] <= pipe_q[1];
         pipe_q[1] <= pipe_q[0];
         if (id_valid && !stall_c)
            pipe_q[0] <= {1'b1, writes, loads, id_dst};
         else
            pipe_q[0] <= '0;
         if (stall_c && stall_cycles != '1)
            stall_cycles <= stall_cycles + 16'd1;
      end
   end

endmodule

// File: tb/tb_hazard_scheduler.sv
// Directed bench for hazard_scheduler; expectations follow the HAZARD_FWD_EN setting of the build.
module tb_hazard_scheduler;

   localparam logic [2:0] NOP = 3'd0;
   localparam logic [2:0] LDD = 3'd1;
   localparam logic [2:0] STD = 3'd2;
   localparam logic [2:0] ADD = 3'd3;
   localparam logic [2:0] NOT = 3'd4;

   logic        clk = 1'b0;
   logic        rst;
   logic        id_valid;
   logic [2:0]  id_opcode;
   logic [2:0]  id_src1;
   logic [2:0]  id_src2;
   logic [2:0]  id_dst;
   logic        stall;
   logic        bubble;
   logic [1:0]  fwd_a;
   logic [1:0]  fwd_b;
   logic [15:0] stall_cycles;

   int checks   = 0;
   int failures = 0;
   int exp_cnt  = 0;

   hazard_scheduler dut (
      .clk          (clk),
      .rst          (rst),
      .id_valid     (id_valid),
      .id_opcode    (id_opcode),
      .id_src1      (id_src1),
      .id_src2      (id_src2),
      .id_dst       (id_dst),
      .stall        (stall),
      .bubble       (bubble),
      .fwd_a        (fwd_a),
      .fwd_b        (fwd_b),
      .stall_cycles (stall_cycles)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic set_id(input logic v, input logic [2:0] op, input logic [2:0] s1,
                         input logic [2:0] s2, input logic [2:0] d);
      id_valid  = v;
      id_opcode = op;
      id_src1   = s1;
      id_src2   = s2;
      id_dst    = d;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Check outputs mid-cycle, then advance one edge; fwd is only defined when not stalling.
   task automatic cyc(input string tag, input logic st, input logic [1:0] fa, input logic [1:0] fb);
      #3;
      check_eq({tag, "_stall"}, {15'd0, stall}, {15'd0, st});
      check_eq({tag, "_bubble"}, {15'd0, bubble}, {15'd0, st});
      check_eq({tag, "_cnt"}, stall_cycles, exp_cnt[15:0]);
      if (!st) begin
         check_eq({tag, "_fwd_a"}, {14'd0, fwd_a}, {14'd0, fa});
         check_eq({tag, "_fwd_b"}, {14'd0, fwd_b}, {14'd0, fb});
      end
      tick();
      if (st) exp_cnt++;
   endtask

   initial begin
      rst = 1'b1;
      set_id(1'b0, NOP, 3'd0, 3'd0, 3'd0);
      #3;
      check_eq("rst_stall", {15'd0, stall}, 16'd0);
      check_eq("rst_fwd", {12'd0, fwd_a, fwd_b}, 16'd0);
      check_eq("rst_cnt", stall_cycles, 16'd0);
      @(negedge clk);
      rst = 1'b0;
      tick();

`ifdef HAZARD_FWD_EN
      set_id(1'b1, ADD, 3'd2, 3'd3, 3'd1); cyc("f_add_r1", 1'b0, 2'b00, 2'b00);
      set_id(1'b1, ADD, 3'd1, 3'd1, 3'd4); cyc("f_ex_fwd", 1'b0, 2'b01, 2'b01);
      set_id(1'b1, LDD, 3'd0, 3'd0, 3'd2); cyc("f_ldd_r2", 1'b0, 2'b00, 2'b00);
      set_id(1'b1, NOT, 3'd2, 3'd0, 3'd5); cyc("f_lu_stall", 1'b1, 2'b00, 2'b00);
      cyc("f_lu_go", 1'b0, 2'b10, 2'b00);
      check_eq("f_lu_cnt", stall_cycles, 16'd1);
      set_id(1'b1, ADD, 3'd0, 3'd0, 3'd1); cyc("f_add_r1b", 1'b0, 2'b00, 2'b00);
      set_id(1'b1, NOP, 3'd0, 3'd0, 3'd0); cyc("f_nop", 1'b0, 2'b00, 2'b00);
      set_id(1'b1, STD, 3'd1, 3'd6, 3'd0); cyc("f_mem_fwd", 1'b0, 2'b10, 2'b00);
      set_id(1'b1, ADD, 3'd0, 3'd0, 3'd3); cyc("f_add_r3a", 1'b0, 2'b00, 2'b00);
      set_id(1'b1, ADD, 3'd0, 3'd0, 3'd3); cyc("f_add_r3b", 1'b0, 2'b00, 2'b00);
      set_id(1'b1, ADD, 3'd3, 3'd3, 3'd4); cyc("f_prio", 1'b0, 2'b01, 2'b01);
      set_id(1'b1, LDD, 3'd0, 3'd0, 3'd6); cyc("f_ldd_r6", 1'b0, 2'b00, 2'b00);
      set_id(1'b1, STD, 3'd4, 3'd6, 3'd0); cyc("f_lu_b", 1'b1, 2'b00, 2'b00);
      cyc("f_lu_b_go", 1'b0, 2'b00, 2'b10);
`else
      set_id(1'b1, ADD, 3'd2, 3'd3, 3'd1); cyc("n_add_r1", 1'b0, 2'b00, 2'b00);
      set_id(1'b1, ADD, 3'd1, 3'd3, 3'd2); cyc("n_raw_s1", 1'b1, 2'b00, 2'b00);
      cyc("n_raw_s2", 1'b1, 2'b00, 2'b00);
      cyc("n_raw_go", 1'b0, 2'b00, 2'b00);
      check_eq("n_raw_cnt", stall_cycles, 16'd2);
      set_id(1'b1, ADD, 3'd0, 3'd0, 3'd4); cyc("n_add_r4", 1'b0, 2'b00, 2'b00);
      set_id(1'b1, ADD, 3'd6, 3'd6, 3'd5); cyc("n_add_r5", 1'b0, 2'b00, 2'b00);
      set_id(1'b1, ADD, 3'd0, 3'd4, 3'd7); cyc("n_d2_s", 1'b1, 2'b00, 2'b00);
      cyc("n_d2_go", 1'b0, 2'b00, 2'b00);
      set_id(1'b1, STD, 3'd0, 3'd0, 3'd6); cyc("n_std", 1'b0, 2'b00, 2'b00);
      set_id(1'b1, ADD, 3'd6, 3'd6, 3'd1); cyc("n_std_nowr", 1'b0, 2'b00, 2'b00);
      set_id(1'b1, STD, 3'd0, 3'd1, 3'd0); cyc("n_std_s2a", 1'b1, 2'b00, 2'b00);
      cyc("n_std_s2b", 1'b1, 2'b00, 2'b00);
      cyc("n_std_go", 1'b0, 2'b00, 2'b00);
      set_id(1'b1, ADD, 3'd0, 3'd0, 3'd5); cyc("n_add_r5b", 1'b0, 2'b00, 2'b00);
      set_id(1'b1, NOT, 3'd0, 3'd5, 3'd6); cyc("n_not_s2", 1'b0, 2'b00, 2'b00);
      set_id(1'b1, NOT, 3'd5, 3'd0, 3'd7); cyc("n_not_s1", 1'b1, 2'b00, 2'b00);
      cyc("n_not_go", 1'b0, 2'b00, 2'b00);
      set_id(1'b1, LDD, 3'd0, 3'd7, 3'd2); cyc("n_ldd_s2", 1'b0, 2'b00, 2'b00);
      set_id(1'b1, LDD, 3'd2, 3'd0, 3'd3); cyc("n_ldd_a", 1'b1, 2'b00, 2'b00);
      cyc("n_ldd_b", 1'b1, 2'b00, 2'b00);
      cyc("n_ldd_go", 1'b0, 2'b00, 2'b00);
      set_id(1'b1, NOP, 3'd3, 3'd3, 3'd3); cyc("n_nop_src", 1'b0, 2'b00, 2'b00);
`endif

      set_id(1'b1, 3'd6, 3'd0, 3'd0, 3'd1); cyc("op6", 1'b0, 2'b00, 2'b00);
      set_id(1'b1, ADD, 3'd1, 3'd1, 3'd2); cyc("op6_nowr", 1'b0, 2'b00, 2'b00);
      set_id(1'b1, ADD, 3'd0, 3'd0, 3'd3); cyc("add_r3", 1'b0, 2'b00, 2'b00);
      set_id(1'b0, ADD, 3'd3, 3'd3, 3'd3); cyc("invalid", 1'b0, 2'b00, 2'b00);

      set_id(1'b1, LDD, 3'd0, 3'd0, 3'd1); cyc("ldd_r1", 1'b0, 2'b00, 2'b00);
      set_id(1'b1, ADD, 3'd1, 3'd1, 3'd2);
      #3;
      check_eq("pre_rst_stall", {15'd0, stall}, 16'd1);
      rst = 1'b1;
      #1;
      exp_cnt = 0;
      check_eq("mid_rst_stall", {15'd0, stall}, 16'd0);
      check_eq("mid_rst_bubble", {15'd0, bubble}, 16'd0);
      check_eq("mid_rst_fwd", {12'd0, fwd_a, fwd_b}, 16'd0);
      check_eq("mid_rst_cnt", stall_cycles, 16'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check_eq("post_rst_stall", {15'd0, stall}, 16'd0);
      tick();
      cyc("post_rst_issue", 1'b0, 2'b00, 2'b00);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
